// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum accumulator stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sum_acc_pkg;

    // Width of the upstream 4-bit adder's Sum output (4 bits plus carry).
    localparam int SUM_W_DEF = 5;

    // Accumulating samples, or holding a finished block total for the consumer.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sum_acc_state_t;

    // Sample counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Sums blocks of N unsigned adder samples into an ACC_W-bit total with a sticky overflow flag.
// Latency: out_valid rises the cycle after the Nth accepted sample; min block period N+1 cycles.
// Backpressure: in_ready drops while a total is pending; the total is held stable until out_ready.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int N     = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    sum_acc_state_t   state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_sticky;

    // One extra bit on the adder so the carry-out is visible as overflow.
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic             last_sample;

    // Zero-extended accumulate of the incoming sample, plus end-of-block detect.
    always_comb begin
        sum_ext     = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
        carry       = sum_ext[ACC_W];
        last_sample = (cnt == LAST_CNT);
    end

    // Block FSM: accumulate N samples, then present the total until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_total  <= '0;
            out_ovf    <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        if (last_sample) begin
                            // Final sample: publish the total and start the next block clean.
                            out_total  <= sum_ext[ACC_W-1:0];
                            out_ovf    <= ovf_sticky | carry;
                            out_valid  <= 1'b1;
                            in_ready   <= 1'b0;
                            acc        <= '0;
                            cnt        <= '0;
                            ovf_sticky <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            acc        <= sum_ext[ACC_W-1:0];
                            cnt        <= cnt + CNT_W'(1);
                            ovf_sticky <= ovf_sticky | carry;
                        end
                    end
                end
                HOLD: begin
                    // Samples are refused here; outputs stay frozen until the consumer takes them.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 4-bit adder's 5-bit `Sum` result. It accepts a stream of sums over a valid/ready handshake and accumulates a fixed-size block of `N` samples into a wider register. It then presents the block total, plus an overflow flag, on an output valid/ready handshake. This turns the combinational adder into a sequential, back-pressured datapath stage.

## Interface
Parameters:
- `SUM_W`, 5: input sample width; matches the adder's `Sum` output.
- `N`, 4: samples per block; legal range 2..256.
- `ACC_W`, 8: accumulator and total width; must be ≥ `SUM_W`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_sum` is valid.
- `in_ready`, out, 1: block can accept a sample.
- `in_sum`, in, `SUM_W`: unsigned sample (adder `Sum`).
- `out_valid`, out, 1: `out_total` and `out_ovf` are valid.
- `out_ready`, in, 1: consumer accepts the block result.
- `out_total`, out, `ACC_W`: block sum modulo 2^`ACC_W`.
- `out_ovf`, out, 1: the block's true sum exceeded 2^`ACC_W` − 1.

## Operation
- FSM states: `ACCUM` and `HOLD`. Reset enters `ACCUM`.
- Reset values: `in_ready`=1, `out_valid`=0, `out_total`=0, `out_ovf`=0. Internal accumulator, sample count and sticky overflow are all 0.
- **ACCUM**
  - `in_ready`=1.
  - Accept when `in_valid && in_ready`.
  - On accept, the accumulator becomes acc + zero-extended `in_sum`. The addition is `ACC_W`+1 bits wide; any carry-out sets sticky overflow.
  - On accept, count increments.
- **Block completion**
  - Trigger: accepting the sample at count = `N`−1.
  - Register the final sum into `out_total`, and the sticky overflow OR this cycle's carry into `out_ovf`.
  - Set `out_valid`=1, clear the accumulator, count and sticky overflow, and go to `HOLD`.
- **HOLD**
  - `in_ready`=0. `in_valid` is ignored and the sample is not consumed.
  - `out_total` and `out_ovf` stay stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`: `out_valid`=0 and return to `ACCUM`. `in_ready`=1 from the next cycle.
- Arithmetic is unsigned. Wrap is modulo 2^`ACC_W`, and overflow is reported, never saturated.
- Reset mid-block: the partial accumulation is discarded with no output. Reset in `HOLD`: the pending result is dropped and `out_valid` deasserts next cycle.
- `in_valid` low for any number of cycles in `ACCUM`: state holds unchanged.

## Timing
- `in_ready` and `out_valid` are registered. Neither depends combinationally on `in_valid` or `out_ready`.
- Latency: `out_valid` rises the cycle after the Nth sample's accept edge.
- Minimum block period: `N`+1 cycles (`N` accepts plus one `HOLD` handoff cycle with immediate `out_ready`). Sustained throughput is `N` samples per `N`+1 cycles.
- `HOLD` persists indefinitely under back-pressure, with outputs held stable.
- A sample is consumed only on a clock edge where `in_valid && in_ready`. An output is consumed only on a clock edge where `out_valid && out_ready`.

## Structure
- Shared package `sum_acc_pkg` contains:
  - state enum `sum_acc_state_t` { `ACCUM`, `HOLD` };
  - constant `SUM_W_DEF`=5, shared with the adder's output width.
- The count register is `$clog2(N)` bits wide, with a minimum of 1.
- No sub-module: the FSM, accumulator and counter are a single module. The `ACC_W`+1 adder is inferred inline.

## Test plan
- **Basic block:** reset, then feed 1, 2, 3, 4 back-to-back with `out_ready`=1 -> `out_total`=10 and `out_ovf`=0. `out_valid` is high for exactly 1 cycle, one cycle after the 4th accept.
- **Back-pressure:** complete a block of 30, 30, 30, 30 with `out_ready`=0 for 5 cycles -> `out_total`=120 held stable and `in_ready`=0 throughout. Any `in_valid` pulses during `HOLD` are not accumulated into the next block.
- **Overflow (`N`=16, `ACC_W`=8):** feed sixteen samples of 31 -> `out_total`=496 mod 256=240 and `out_ovf`=1. The following block of sixteen 1s gives `out_total`=16 and `out_ovf`=0, confirming the sticky flag clears.
- **Gapped input:** feed 5, 6, 7, 8 with random `in_valid` gaps -> `out_total`=26, and the count advances only on handshakes.
- **Reset mid-block:** feed 9, 9, assert `rst` for 1 cycle, then feed 1, 1, 1, 1 -> `out_total`=4. There is no output for the aborted block.
- **Reset in `HOLD`:** assert `rst` while `out_valid`=1 -> `out_valid`=0 and `in_ready`=1 after the reset edge.
